mem_bist_ctrl: RTL

Upstream traffic master for the `memory` block. It sequences a write sweep followed by a read-back sweep over a configurable address window, using memory's valid/ready handshake. It regenerates the expected data, compares every read beat, and reports pass/fail, the first failing address and an error count. It replaces bench-driven frontdoor access for self-checking in silicon and in simulation.

---
 rtl/mem_bist_ctrl.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/mem_bist_ctrl.sv
// Memory BIST traffic master: write sweep then read-back sweep over an address
// window, comparing read data against a regenerated pattern.
module mem_bist_ctrl #(
    parameter int          WIDTH   = 32,
    parameter int          DEPTH   = 256,
    parameter int          ADDR    = 8,
    parameter logic [31:0] SEED    = 32'hACE12345,
    parameter int          TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [ADDR-1:0]  start_addr,
    input  logic [ADDR:0]    num_loc,
    input  logic [1:0]       mode,
    output logic [ADDR-1:0]  addr,
    output logic [WIDTH-1:0] wdata,
    output logic             wrbar,
    output logic             valid,
    input  logic [WIDTH-1:0] rdata,
    input  logic             ready,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             timeout,
    output logic [ADDR:0]    err_cnt,
    output logic [ADDR-1:0]  first_err_addr,
    output logic [1:0]       dbg_state
);

    // Handshake: a beat transfers at the rising edge where valid && ready; while
    // valid is high and ready low, addr/wdata/wrbar are held unchanged.

    typedef enum logic [1:0] {S_IDLE, S_WRITE, S_READ, S_DONE} state_t;

    localparam int          WD       = $clog2(TIMEOUT + 1);
    localparam logic [31:0] SEED_EFF = (SEED == 32'd0) ? 32'd1 : SEED;
    localparam logic [ADDR:0] DEPTH_L = DEPTH[ADDR:0];
    localparam logic [WD-1:0] WD_LAST = WD'(TIMEOUT - 1);

    state_t          state_q, state_d;
    logic [ADDR-1:0] base_q;
    logic [ADDR:0]   num_q, k_q, num_clamp, err_d;
    logic [1:0]      mode_q;
    logic [31:0]     lfsr_q, lfsr_step;
    logic [WD-1:0]   wd_q;
    logic [ADDR-1:0] cur_addr;
    logic [WIDTH-1:0] pattern;
    logic            start_ok, beat, last, stall, wd_expire, mismatch;

    assign num_clamp = (num_loc > DEPTH_L) ? DEPTH_L : num_loc;
    assign start_ok  = start && (state_q == S_IDLE || state_q == S_DONE);
    assign beat      = valid && ready;
    assign stall     = valid && !ready;
    assign last      = (k_q == num_q - 1'b1);
    assign wd_expire = stall && (wd_q == WD_LAST);
    assign cur_addr  = base_q + k_q[ADDR-1:0];
    assign lfsr_step = (lfsr_q >> 1) ^ (lfsr_q[0] ? 32'h80200003 : 32'h0);
    assign mismatch  = (state_q == S_READ) && beat && (rdata != pattern);
    assign err_d     = (mismatch && !(&err_cnt)) ? err_cnt + 1'b1 : err_cnt;

    // Mode 3 is reserved and falls back to the address pattern.
    always_comb begin
        pattern = WIDTH'(cur_addr);
        case (mode_q)
            2'd1: pattern = ~WIDTH'(cur_addr);
            2'd2: for (int i = 0; i < WIDTH; i++) pattern[i] = lfsr_q[i[4:0]];
            default: pattern = WIDTH'(cur_addr);
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE: if (start_ok) state_d = (num_clamp == '0) ? S_DONE : S_WRITE;
            S_WRITE: begin
                if (wd_expire)         state_d = S_DONE;
                else if (beat && last) state_d = S_READ;
            end
            S_READ: begin
                if (wd_expire)         state_d = S_DONE;
                else if (beat && last) state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        valid     = (state_q == S_WRITE) || (state_q == S_READ);
        wrbar     = (state_q == S_WRITE);
        busy      = valid;
        done      = (state_q == S_DONE);
        addr      = cur_addr;
        wdata     = (state_q == S_WRITE) ? pattern : '0;
        dbg_state = state_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            base_q         <= '0;
            num_q          <= '0;
            mode_q         <= '0;
            k_q            <= '0;
            lfsr_q         <= SEED_EFF;
            wd_q           <= '0;
            pass           <= 1'b0;
            timeout        <= 1'b0;
            err_cnt        <= '0;
            first_err_addr <= '0;
        end else if (start_ok) begin
            base_q         <= start_addr;
            num_q          <= num_clamp;
            mode_q         <= mode;
            k_q            <= '0;
            lfsr_q         <= SEED_EFF;
            wd_q           <= '0;
            pass           <= (num_clamp == '0);
            timeout        <= 1'b0;
            err_cnt        <= '0;
            first_err_addr <= '0;
        end else if (valid) begin
            if (beat) begin
                wd_q <= '0;
                // Both sweeps restart the pattern from the seed at k=0.
                if (last) begin
                    k_q    <= '0;
                    lfsr_q <= SEED_EFF;
                end else begin
                    k_q    <= k_q + 1'b1;
                    lfsr_q <= lfsr_step;
                end
                if (state_q == S_READ && last) pass <= (err_d == '0) && !timeout;
            end else if (wd_expire) begin
                timeout <= 1'b1;
                pass    <= 1'b0;
            end else begin
                wd_q <= wd_q + 1'b1;
            end
            if (mismatch) begin
                err_cnt <= err_d;
                if (err_cnt == '0) first_err_addr <= cur_addr;
            end
        end
    end

endmodule
